// File: rtl/tdm_demux_deserializer.sv
// tdm_demux_deserializer
// Receives a serial stream carrying N_CH time-multiplexed channels of W bits
// each (channel 0 first, MSB first), aligned by frame_start, and presents each
// completed frame atomically on ch_data together with a one-cycle frame_valid.
// An early frame_start aborts the partial frame, pulses sync_err and restarts.
module tdm_demux_deserializer #(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial_in,
  input  logic              bit_valid,
  input  logic              frame_start,
  output logic [N_CH*W-1:0] ch_data,
  output logic              frame_valid,
  output logic              sync_err
);

  localparam int BW = $clog2(W);
  localparam int CW = $clog2(N_CH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state;
  state_t              state_next;
  logic [BW-1:0]       bit_cnt;
  logic [CW-1:0]       ch_cnt;
  logic [W-1:0]        shift_reg;
  logic [N_CH*W-1:0]   staging;

  // Decoded per-cycle actions
  logic                start_bit;   // this bit becomes bit 0 of channel 0
  logic                shift_bit;   // ordinary in-frame bit
  logic                word_done;   // this bit completes a channel word
  logic                frame_done;  // this bit completes the whole frame
  logic                abort;       // early frame_start while collecting

  // Word as it stands once the current bit is shifted in at the LSB
  logic [W-1:0]        word;
  // Staging buffer with the word just completed merged into its slot
  logic [N_CH*W-1:0]   merged;

  assign word = {shift_reg[W-2:0], serial_in};

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_merge
      assign merged[gi*W +: W] = (word_done && (ch_cnt == CW'(gi)))
                                 ? word : staging[gi*W +: W];
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and action decode; an early frame_start wins over completion
  always_comb begin
    state_next = state;
    start_bit  = 1'b0;
    shift_bit  = 1'b0;
    word_done  = 1'b0;
    frame_done = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (bit_valid && frame_start) begin
          start_bit  = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          if (frame_start) begin
            start_bit = 1'b1;
            abort     = 1'b1;
          end else begin
            shift_bit = 1'b1;
            if (bit_cnt == BW'(W - 1)) begin
              word_done = 1'b1;
              if (ch_cnt == CW'(N_CH - 1)) begin
                frame_done = 1'b1;
                state_next = IDLE;
              end
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: shift register, counters, staging buffer and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      ch_cnt      <= '0;
      shift_reg   <= '0;
      staging     <= '0;
      ch_data     <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= frame_done;
      sync_err    <= abort;
      if (start_bit) begin
        shift_reg <= word;
        bit_cnt   <= BW'(1);
        ch_cnt    <= '0;
      end else if (shift_bit) begin
        shift_reg <= word;
        if (word_done) begin
          bit_cnt <= '0;
          staging <= merged;
          ch_cnt  <= frame_done ? '0 : ch_cnt + 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (frame_done) ch_data <= merged;
    end
  end

endmodule

// File: tb/tb_tdm_demux_deserializer.sv
// Bench for tdm_demux_deserializer: directed frames drive the serial input,
// expected frames and sync_err pulses (with their due cycle) go into queues,
// and an independent negedge monitor pops and compares.
module tb_tdm_demux_deserializer;

  localparam int N_CH = 4;
  localparam int W    = 8;
  localparam int FW   = N_CH * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          serial_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic          frame_start = 1'b0;
  logic [FW-1:0] ch_data;
  logic          frame_valid;
  logic          sync_err;

  tdm_demux_deserializer #(.N_CH(N_CH), .W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .serial_in   (serial_in),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .ch_data     (ch_data),
    .frame_valid (frame_valid),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [FW-1:0] data;
    int            due;
  } exp_t;

  exp_t          exp_q[$];
  int            sync_q[$];
  logic [FW-1:0] model = '0;
  bit            in_frame = 1'b0;
  int            n_vec = 0;
  int            n_fail = 0;

  // Monitor: checks outputs each negedge against the scoreboard queues
  always @(negedge clk) begin
    if (!rst_n) begin
      n_vec++;
      if (ch_data !== '0 || frame_valid !== 1'b0 || sync_err !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: ch_data=%h fv=%b se=%b, required all 0",
                 ch_data, frame_valid, sync_err);
      end
      model = '0;
    end else begin
      if (frame_valid && sync_err) begin
        n_vec++;
        n_fail++;
        $display("FAIL fv_se_overlap: both high at cycle %0d, required exclusive", cyc);
      end
      if (frame_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_frame: frame_valid at cycle %0d ch_data=%h, required none",
                   cyc, ch_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (ch_data !== e.data || cyc != e.due) begin
            n_fail++;
            $display("FAIL frame: got %h at cycle %0d, required %h at cycle %0d",
                     ch_data, cyc, e.data, e.due);
          end
          model = e.data;
        end
      end else begin
        n_vec++;
        if (ch_data !== model) begin
          n_fail++;
          $display("FAIL ch_data_hold: got %h at cycle %0d, required %h",
                   ch_data, cyc, model);
        end
      end
      if (sync_err) begin
        n_vec++;
        if (sync_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_sync_err: pulse at cycle %0d, required none", cyc);
        end else begin
          int d;
          d = sync_q.pop_front();
          if (cyc != d) begin
            n_fail++;
            $display("FAIL sync_err: pulse at cycle %0d, required cycle %0d", cyc, d);
          end else begin
            $display("sync_err pulse at cycle %0d ok", cyc);
          end
        end
      end
      if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
        exp_t m;
        m = exp_q.pop_front();
        n_vec++;
        n_fail++;
        $display("FAIL missing_frame: no frame_valid, required %h at cycle %0d", m.data, m.due);
      end
      if (sync_q.size() > 0 && cyc > sync_q[0]) begin
        int m;
        m = sync_q.pop_front();
        n_vec++;
        n_fail++;
        $display("FAIL missing_sync_err: no sync_err pulse, required at cycle %0d", m);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      bit_valid   = 1'b0;
      frame_start = 1'b0;
      serial_in   = 1'($urandom);
    end
  endtask

  task automatic send_bit(input logic b, input logic fs);
    step();
    serial_in   = b;
    bit_valid   = 1'b1;
    frame_start = fs;
  endtask

  // Sends the first nbits of frame d; a full frame pushes its expected result
  task automatic send_frame(input logic [FW-1:0] d, input int nbits, input int maxgap);
    for (int i = 0; i < nbits; i++) begin
      int ch;
      int b;
      ch = i / W;
      b  = W - 1 - (i % W);
      send_bit(d[ch*W + b], (i == 0));
      if (i == 0 && in_frame) sync_q.push_back(cyc + 1);
      if (i == 0) in_frame = 1'b1;
      if (i == FW - 1) begin
        exp_t e;
        e.data = d;
        e.due  = cyc + 1;
        exp_q.push_back(e);
        in_frame = 1'b0;
        $display("frame %h issued, due cycle %0d", d, e.due);
      end
      if (maxgap > 0 && i != nbits - 1) idle($urandom_range(1, maxgap));
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (4) begin
      step();
      serial_in   = 1'($urandom);
      bit_valid   = 1'($urandom);
      frame_start = 1'($urandom);
    end
    step();
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    rst_n       = 1'b1;
    idle(3);

    // Single frame A5,3C,FF,01
    send_frame(32'h01FF3CA5, FW, 0);
    idle(3);
    // Same frame with random 1..5 cycle gaps
    send_frame(32'h01FF3CA5, FW, 5);
    idle(2);
    // 10 unaligned bits are ignored, then a frame
    repeat (10) send_bit(1'($urandom), 1'b0);
    send_frame(32'h12345678, FW, 0);
    idle(3);
    // Back-to-back frames
    send_frame(32'h01FF3CA5, FW, 0);
    send_frame(32'h44332211, FW, 0);
    idle(3);
    // Early resync at bit 13, then DE,AD,BE,EF
    send_frame(32'h01FF3CA5, 13, 0);
    send_frame(32'hEFBEADDE, FW, 0);
    idle(3);
    // Reset at bit 20, then a clean frame
    send_frame(32'h0F0F0F0F, 20, 0);
    step();
    rst_n = 1'b0;
    repeat (2) begin
      step();
      serial_in   = 1'($urandom);
      bit_valid   = 1'($urandom);
      frame_start = 1'($urandom);
    end
    step();
    rst_n       = 1'b1;
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    in_frame    = 1'b0;
    idle(2);
    send_frame(32'h87654321, FW, 0);
    idle(3);

    for (int k = 0; k < 100 && (exp_q.size() > 0 || sync_q.size() > 0); k++) step();
    while (exp_q.size() > 0) begin
      exp_t m;
      m = exp_q.pop_front();
      n_vec++;
      n_fail++;
      $display("FAIL timeout_frame: never seen, required %h", m.data);
    end
    while (sync_q.size() > 0) begin
      int m;
      m = sync_q.pop_front();
      n_vec++;
      n_fail++;
      $display("FAIL timeout_sync_err: never seen, required at cycle %0d", m);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
